// File: rtl/sync_debounce_edge_pkg.sv
// sync_debounce_edge_pkg: shared state encoding and counter-width helper for the debounce block
package sync_debounce_edge_pkg;
  typedef enum logic {ST_STABLE = 1'b0, ST_QUALIFY = 1'b1} state_t;
  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction
endpackage

// File: rtl/sat_cnt_n.sv
// sat_cnt_n: saturating up-counter with synchronous clear taking priority over increment
module sat_cnt_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: glitch filter on a synchronized level with rise/fall pulses and aborted-qualification count
module sync_debounce_edge
  import sync_debounce_edge_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   GLITCH_CNT_W    = 8,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                    clki,
  input  logic                    rst,
  input  logic                    sync_data_i,
  input  logic                    enable_i,
  input  logic                    glitch_clr_i,
  output logic                    level_o,
  output logic                    rise_o,
  output logic                    fall_o,
  output logic                    busy_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic diff, flip, abort;
  always_comb begin
    diff    = sync_data_i ^ level_o;
    flip    = enable_i && diff && (state == ST_QUALIFY ? cnt == LAST : DEBOUNCE_CYCLES == 1);
    abort   = enable_i && state == ST_QUALIFY && !diff;
    state_n = (enable_i && diff && !flip) ? ST_QUALIFY : ST_STABLE;
    cnt_n   = state_n == ST_QUALIFY ? cnt + CW'(1) : '0;
  end
  always_ff @(posedge clki or posedge rst)
    if (rst) begin
      state   <= ST_STABLE;
      cnt     <= '0;
      level_o <= RESET_LEVEL;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      level_o <= level_o ^ flip;
      rise_o  <= flip && !level_o;
      fall_o  <= flip && level_o;
    end
  assign busy_o = (state == ST_QUALIFY);
  sat_cnt_n #(.W(GLITCH_CNT_W)) u_glitch (
    .clk(clki),
    .rst(rst),
    .inc(abort),
    .clr(glitch_clr_i),
    .cnt(glitch_cnt_o)
  );
endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: table-driven and directed checks of the debounce filter at D=4, D=1 and a 2-bit glitch counter
module tb_sync_debounce_edge;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic d0 = 1'b1, en0 = 1'b1, clr0 = 1'b0, lvl0, ri0, fa0, bu0;
  logic [7:0] gc0;
  logic d1 = 1'b0, lvl1, ri1, fa1, bu1;
  logic [7:0] gc1;
  logic d2 = 1'b0, clr2 = 1'b0, lvl2, ri2, fa2, bu2;
  logic [1:0] gc2;
  int total = 0, passed = 0;
  sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .GLITCH_CNT_W(8)) u0 (
    .clki(clk), .rst(rst), .sync_data_i(d0), .enable_i(en0), .glitch_clr_i(clr0),
    .level_o(lvl0), .rise_o(ri0), .fall_o(fa0), .busy_o(bu0), .glitch_cnt_o(gc0));
  sync_debounce_edge #(.DEBOUNCE_CYCLES(1), .GLITCH_CNT_W(8)) u1 (
    .clki(clk), .rst(rst), .sync_data_i(d1), .enable_i(1'b1), .glitch_clr_i(1'b0),
    .level_o(lvl1), .rise_o(ri1), .fall_o(fa1), .busy_o(bu1), .glitch_cnt_o(gc1));
  sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .GLITCH_CNT_W(2)) u2 (
    .clki(clk), .rst(rst), .sync_data_i(d2), .enable_i(1'b1), .glitch_clr_i(clr2),
    .level_o(lvl2), .rise_o(ri2), .fall_o(fa2), .busy_o(bu2), .glitch_cnt_o(gc2));
  typedef struct {
    logic d, en, clr;
    logic lvl, rise, fall, busy;
    int   gc;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic d, en, clr, lvl, rise, fall, busy, input int gc, input int n = 1);
    vec_t v;
    v.d = d; v.en = en; v.clr = clr; v.lvl = lvl; v.rise = rise; v.fall = fall; v.busy = busy; v.gc = gc;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // D=4 main sequence; rows give inputs before an edge and outputs after it
    add(1, 1, 0, 0, 0, 0, 1, 0, 3);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 3);
    add(1, 1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1, 1, 3);
    add(0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 1, 3);
    add(0, 1, 0, 0, 0, 0, 0, 2, 2);
    add(1, 1, 0, 0, 0, 0, 1, 2, 2);
    add(1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 0, 1, 2, 3);
    add(1, 1, 0, 1, 1, 0, 0, 2);
    add(1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 3);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 3);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 2);
    tick();
    tick();
    check("rst_level", lvl0, 0);
    check("rst_rise", ri0, 0);
    check("rst_fall", fa0, 0);
    check("rst_busy", bu0, 0);
    check("rst_gcnt", gc0, 0);
    rst = 1'b0;
    foreach (vq[i]) begin
      d0 = vq[i].d; en0 = vq[i].en; clr0 = vq[i].clr;
      tick();
      check($sformatf("v%0d_level", i), lvl0, vq[i].lvl);
      check($sformatf("v%0d_rise", i), ri0, vq[i].rise);
      check($sformatf("v%0d_fall", i), fa0, vq[i].fall);
      check($sformatf("v%0d_busy", i), bu0, vq[i].busy);
      check($sformatf("v%0d_gcnt", i), gc0, vq[i].gc);
    end
    // u0 is now mid-qualification with level 1; reset must act without a clock edge
    #2 rst = 1'b1;
    #1;
    check("arst_level", lvl0, 0);
    check("arst_busy", bu0, 0);
    check("arst_gcnt", gc0, 0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      d2 = 1'b1;
      tick();
      check("sat_busy", bu2, 1);
      d2 = 1'b0;
      tick();
      check($sformatf("sat_gcnt%0d", i), gc2, i > 3 ? 3 : i);
    end
    d2 = 1'b1;
    tick();
    d2 = 1'b0; clr2 = 1'b1;
    tick();
    check("clr_wins", gc2, 0);
    clr2 = 1'b0;
    check("sat_level", lvl2, 0);
    for (int i = 0; i < 8; i++) begin
      d1 = ((i >> 1) % 2) == 0;
      tick();
      check($sformatf("d1_level%0d", i), lvl1, d1);
      check($sformatf("d1_rise%0d", i), ri1, (i % 2 == 0) && d1);
      check($sformatf("d1_fall%0d", i), fa1, (i % 2 == 0) && !d1);
      check($sformatf("d1_busy%0d", i), bu1, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
